mont_const_gen: RTL and testbench

MONT_CONST_GEN -- requirements
Module: mont_const_gen

---
 rtl/mont_const_gen.sv | 103 ++++++++++
 tb/tb_mont_const_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mont_const_gen.sv
`default_nettype none
// mont_const_gen: produces R^2 mod P (R = 2^WIDTH) by 2*WIDTH rounds of
// doubling with conditional subtraction, starting from a remainder of 1.
module mont_const_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] const_out
);

  localparam int            CW   = $clog2(2 * WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] const_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH:0]   r_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] p_ext;
  logic             p_valid;

  // r < P holds throughout, so 2r < 2P always fits in WIDTH+2 bits
  always_comb begin
    t     = {r_q, 1'b0};
    p_ext = {2'b00, p_q};
    r_d   = (t >= p_ext) ? (WIDTH + 1)'(t - p_ext) : t[WIDTH:0];
  end

  assign p_valid = P[0] && (P != WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      const_q <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            p_q    <= P;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            r_q    <= (WIDTH + 1)'(1);
            if (p_valid) begin
              state_q <= CALC;
            end else begin
              err_q   <= 1'b1;
              const_q <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            const_q <= r_d[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign const_out = const_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_const_gen.sv
`default_nettype none
// tb_mont_const_gen: directed vector table, back-to-back, mid-run abort and
// full odd-modulus sweep against an independent 65536 % P reference.
module tb_mont_const_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] P = 8'd0;
  logic       busy, done, err;
  logic [7:0] const_out;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_c = 0;
  int prev_e = 0;

  mont_const_gen #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .P         (P),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .const_out (const_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    int         exp_c;
    int         exp_e;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_one(input logic [7:0] p, input int ec, input int ee, input int elat);
    int lat;
    bit got;
    start = 1'b1;
    P     = p;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1'b1;
      end else begin
        chk("busy_calc", int'(busy), 1);
        if (lat == 1) chk("err_clear", int'(err), 0);
        if (lat == 5) chk("const_held", int'(const_out), prev_c);
        P     = 8'($urandom);
        start = (lat == 3);
      end
    end
    start = 1'b0;
    chk("latency", got ? lat : -1, elat);
    chk("const_out", int'(const_out), ec);
    chk("err", int'(err), ee);
    chk("busy_done", int'(busy), 1);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("const_keep", int'(const_out), ec);
    prev_c = ec;
    prev_e = ee;
  endtask

  vec_t vecs[12];
  int   b2b_p[4] = '{187, 13, 255, 3};
  int   b2b_c[4] = '{86, 3, 1, 1};

  initial begin
    vecs[0]  = '{8'd251, 25, 0, 17};
    vecs[1]  = '{8'd187, 86, 0, 17};
    vecs[2]  = '{8'd13,  3,  0, 17};
    vecs[3]  = '{8'd255, 1,  0, 17};
    vecs[4]  = '{8'd3,   1,  0, 17};
    vecs[5]  = '{8'h40,  0,  1, 1};
    vecs[6]  = '{8'h01,  0,  1, 1};
    vecs[7]  = '{8'd13,  3,  0, 17};
    vecs[8]  = '{8'd0,   0,  1, 1};
    vecs[9]  = '{8'd7,   2,  0, 17};
    vecs[10] = '{8'd9,   7,  0, 17};
    vecs[11] = '{8'd200, 0,  1, 1};

    // reset state
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_const", int'(const_out), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_one(vecs[i].p, vecs[i].exp_c, vecs[i].exp_e, vecs[i].exp_lat);

    // back-to-back with start held high
    begin
      int cyc = 0;
      int n = 0;
      int last = 0;
      start = 1'b1;
      P     = 8'(b2b_p[0]);
      while (n < 4 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          chk("b2b_const", int'(const_out), b2b_c[n]);
          if (n > 0) chk("b2b_spacing", cyc - last, 18);
          last = cyc;
          n++;
          if (n < 4) P = 8'(b2b_p[n]);
          else start = 1'b0;
        end
      end
      start = 1'b0;
      chk("b2b_count", n, 4);
      @(negedge clk);
      prev_c = 1;
    end

    // reset asserted at iteration 5
    start = 1'b1;
    P     = 8'd251;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_const", int'(const_out), 0);
    repeat (2) @(negedge clk);
    chk("abort_nodone", int'(done), 0);
    rst    = 1'b0;
    prev_c = 0;
    run_one(8'd13, 3, 0, 17);

    // sweep all odd P
    for (int p = 3; p < 256; p += 2)
      run_one(8'(p), 65536 % p, 0, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
